// File: rtl/conv_window_feeder.sv
// ---------------------------------------------------------------------------
// conv_window_feeder
//
// Streaming 3x3 window generator for the neuron stage. Pixels arrive in raster
// order, one per handshake. Two line buffers hold the previous two rows. A 3x3
// register window slides across the image. Only windows that lie fully inside
// the image are emitted (valid-only convolution, no padding).
//
// Parameters
//   IMG_W  pixels per line (>= 3)
//   IMG_H  lines per frame (>= 3)
//   DW     signed pixel / tap width
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   pix_data/valid/ready  raster-order pixel input stream
//   win_0 .. win_8        window taps, row-major; win_0 is the oldest pixel
//                         (top-left) and win_8 is the pixel just accepted
//   start_                {9{win_valid}}, drives the neuron start vector
//   win_valid/ready       output handshake (single output register stage)
//   win_last              final window of a frame, qualified by win_valid
//   frame_cnt             completed-frame counter; this port exists only when
//                         the macro FEEDER_FRAME_CNT_EN is defined
// ---------------------------------------------------------------------------
module conv_window_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] pix_data,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic signed [DW-1:0] win_0,
  output logic signed [DW-1:0] win_1,
  output logic signed [DW-1:0] win_2,
  output logic signed [DW-1:0] win_3,
  output logic signed [DW-1:0] win_4,
  output logic signed [DW-1:0] win_5,
  output logic signed [DW-1:0] win_6,
  output logic signed [DW-1:0] win_7,
  output logic signed [DW-1:0] win_8,
  output logic [8:0]           start_,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic                 win_last
`ifdef FEEDER_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Input stage: raster position of the pixel being offered and line buffers.
  logic [CW-1:0]        col_p0;
  logic [RW-1:0]        row_p0;
  logic signed [DW-1:0] lb0_p0 [IMG_W];  // row r-1
  logic signed [DW-1:0] lb1_p0 [IMG_W];  // row r-2
  logic                 acc_p0;
  logic                 col_last_p0;
  logic                 row_last_p0;
  logic                 emit_p0;

  // Output stage: window registers and their handshake state.
  logic signed [DW-1:0] win_p1 [9];
  logic                 vld_p1;
  logic                 last_p1;

  // A new pixel can only enter when the held window is empty or being consumed;
  // accepting a pixel always reshapes the window, so this keeps taps stable
  // under backpressure.
  assign pix_ready   = ~vld_p1 | win_ready;
  assign acc_p0      = pix_valid & pix_ready;
  assign col_last_p0 = (col_p0 == COL_LAST);
  assign row_last_p0 = (row_p0 == ROW_LAST);
  assign emit_p0     = acc_p0 && (row_p0 >= ROW_TWO) && (col_p0 >= COL_TWO);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (acc_p0) begin
      if (col_last_p0) begin
        col_p0 <= '0;
        row_p0 <= row_last_p0 ? '0 : row_p0 + RW'(1);
      end else begin
        col_p0 <= col_p0 + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0_p0[i] <= '0;
        lb1_p0[i] <= '0;
      end
    end else if (acc_p0) begin
      lb1_p0[col_p0] <= lb0_p0[col_p0];
      lb0_p0[col_p0] <= pix_data;
    end
  end

  // ---- stage boundary: p0 -> p1 (window registers) ----
  // Each row of the window shifts left by one column; the incoming column is
  // {row r-2, row r-1, row r} at the current column. The first two columns of
  // every row push out whatever was left from the previous row, so the window
  // is clean again by col = 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        win_p1[k] <= '0;
      end
    end else if (acc_p0) begin
      win_p1[0] <= win_p1[1];
      win_p1[1] <= win_p1[2];
      win_p1[2] <= lb1_p0[col_p0];
      win_p1[3] <= win_p1[4];
      win_p1[4] <= win_p1[5];
      win_p1[5] <= lb0_p0[col_p0];
      win_p1[6] <= win_p1[7];
      win_p1[7] <= win_p1[8];
      win_p1[8] <= pix_data;
    end
  end

  // A qualifying accept in the same cycle as a consume replaces the window,
  // so the emit branch takes priority over the drain branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (emit_p0) begin
      vld_p1  <= 1'b1;
      last_p1 <= row_last_p0 && col_last_p0;
    end else if (vld_p1 && win_ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

`ifdef FEEDER_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (acc_p0 && row_last_p0 && col_last_p0) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  assign win_0     = win_p1[0];
  assign win_1     = win_p1[1];
  assign win_2     = win_p1[2];
  assign win_3     = win_p1[3];
  assign win_4     = win_p1[4];
  assign win_5     = win_p1[5];
  assign win_6     = win_p1[6];
  assign win_7     = win_p1[7];
  assign win_8     = win_p1[8];
  assign win_valid = vld_p1;
  assign win_last  = last_p1;
  assign start_    = {9{vld_p1}};

endmodule

// File: tb/tb_conv_window_feeder.sv
// ---------------------------------------------------------------------------
// tb_conv_window_feeder
//
// Self-checking bench for conv_window_feeder on a 4x4 image. The driver keeps
// a copy of the frame being sent and, for every pixel that completes an
// in-image 3x3 neighbourhood, pushes the expected window onto a scoreboard.
// A monitor pops and compares on every consumed window.
// ---------------------------------------------------------------------------
module tb_conv_window_feeder;

  localparam int IW = 4;
  localparam int IH = 4;
  localparam int DW = 27;

  typedef struct packed {
    logic [8:0][DW-1:0] taps;
    logic               last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] pix_data = '0;
  logic                 pix_valid = 1'b0;
  logic                 pix_ready;
  logic signed [DW-1:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
  logic [8:0]           start_;
  logic                 win_valid;
  logic                 win_ready = 1'b1;
  logic                 win_last;
`ifdef FEEDER_FRAME_CNT_EN
  logic [15:0]          frame_cnt;
  int                   fc_exp = 0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int win_cnt  = 0;

  exp_t               sb[$];
  logic [DW-1:0]      hist0[$];
  logic [DW-1:0]      hist4[$];
  logic [DW-1:0]      hist8[$];
  logic               hist_last[$];
  int                 last_idx[$];
  logic [DW-1:0]      img[IH][IW];
  logic [8:0][DW-1:0] obs_taps;
  exp_t               mon_e;

  conv_window_feeder #(.IMG_W(IW), .IMG_H(IH), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win_0     (win_0),
    .win_1     (win_1),
    .win_2     (win_2),
    .win_3     (win_3),
    .win_4     (win_4),
    .win_5     (win_5),
    .win_6     (win_6),
    .win_7     (win_7),
    .win_8     (win_8),
    .start_    (start_),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_last  (win_last)
`ifdef FEEDER_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs_taps = {win_8, win_7, win_6, win_5, win_4, win_3, win_2, win_1, win_0};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare every window at the moment it is consumed.
  always @(negedge clk) begin
    if (!rst && win_valid && win_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_window", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        for (int k = 0; k < 9; k++)
          check_val($sformatf("tap%0d_win%0d", k, win_cnt), 32'(obs_taps[k]), 32'(mon_e.taps[k]));
        check_val("win_last", 32'(win_last), 32'(mon_e.last));
        check_val("start_", 32'(start_), 32'h1ff);
      end
      win_cnt++;
      hist0.push_back(win_0);
      hist4.push_back(win_4);
      hist8.push_back(win_8);
      hist_last.push_back(win_last);
      if (win_last) last_idx.push_back(win_cnt);
    end
  end

  // Offer one pixel at (r,c); push the expected window when it is accepted.
  task automatic send_pixel(input logic [DW-1:0] val, input int r, input int c);
    exp_t e;
    bit   done = 0;
    img[r][c] = val;
    pix_valid = 1'b1;
    pix_data  = val;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (pix_ready) begin
        if (r >= 2 && c >= 2) begin
          for (int k = 0; k < 9; k++) e.taps[k] = img[r-2+k/3][c-2+k%3];
          e.last = (r == IH-1) && (c == IW-1);
          sb.push_back(e);
        end
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) check_val("send_timeout", 32'd0, 32'd1);
  endtask

  // mode 0: pixel = 10r+c, continuous; mode 1: all -1 with random idle gaps.
  task automatic send_frame(input int mode);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        if (mode == 0) send_pixel(DW'(10*r + c), r, c);
        else begin
          send_pixel({DW{1'b1}}, r, c);
          pix_valid = 1'b0;
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
      end
`ifdef FEEDER_FRAME_CNT_EN
    fc_exp++;
`endif
  endtask

  task automatic drain();
    pix_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check_val("sb_empty", 32'(sb.size()), 32'd0);
`ifdef FEEDER_FRAME_CNT_EN
    check_val("frame_cnt", 32'(frame_cnt), 32'(fc_exp));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef FEEDER_FRAME_CNT_EN
    fc_exp = 0;
`endif
  endtask

  task automatic check_first_test(input int base);
    check_val("count_4x4", 32'(win_cnt - base), 32'd4);
    check_val("w1_win0", 32'(hist0[base]), 32'd0);
    check_val("w1_win4", 32'(hist4[base]), 32'd11);
    check_val("w1_win8", 32'(hist8[base]), 32'd22);
    check_val("w1_last", 32'(hist_last[base]), 32'd0);
    check_val("w4_win0", 32'(hist0[base+3]), 32'd11);
    check_val("w4_win8", 32'(hist8[base+3]), 32'd33);
    check_val("w4_last", 32'(hist_last[base+3]), 32'd1);
  endtask

  initial begin
    int base;
    int t0;
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    // Reset state (still in reset), then release.
    check_val("rst_win_valid", 32'(win_valid), 32'd0);
    check_val("rst_pix_ready", 32'(pix_ready), 32'd1);
    check_val("rst_start", 32'(start_), 32'd0);
    check_val("rst_win_last", 32'(win_last), 32'd0);
    check_val("rst_win8", 32'(win_8), 32'd0);
`ifdef FEEDER_FRAME_CNT_EN
    check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Basic frame.
    base = win_cnt;
    send_frame(0);
    drain();
    check_first_test(base);

    // Backpressure on the first window.
    base = win_cnt;
    win_ready = 1'b0;
    fork
      send_frame(0);
      begin
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
          @(negedge clk);
          if (win_valid) seen = 1;
        end
        if (!seen) check_val("bp_wait_valid", 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check_val("bp_pix_ready", 32'(pix_ready), 32'd0);
          check_val("bp_win_valid", 32'(win_valid), 32'd1);
          check_val("bp_win0", 32'(win_0), 32'd0);
          check_val("bp_win4", 32'(win_4), 32'd11);
          check_val("bp_win8", 32'(win_8), 32'd22);
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
      end
    join
    drain();
    check_first_test(base);

    // All pixels -1, with idle gaps on pix_valid.
    base = win_cnt;
    send_frame(1);
    drain();
    check_val("neg_count", 32'(win_cnt - base), 32'd4);
    check_val("neg_win0", 32'(hist0[base]), 32'h7FFFFFF);
    check_val("neg_win8", 32'(hist8[base+3]), 32'h7FFFFFF);

    // Reset after 6 pixels of a frame.
    for (int i = 0; i < 6; i++) send_pixel(DW'(100 + i), i / IW, i % IW);
    pix_valid = 1'b0;
    do_reset();
    check_val("midrst_win_valid", 32'(win_valid), 32'd0);
    check_val("midrst_pix_ready", 32'(pix_ready), 32'd1);
    base = win_cnt;
    send_frame(0);
    drain();
    check_first_test(base);

    // Two frames back-to-back, pix_valid held high throughout.
    base = win_cnt;
    last_idx.delete();
    t0 = cyc;
    send_frame(0);
    send_frame(0);
    check_val("b2b_cycles", 32'(cyc - t0), 32'(2 * IW * IH));
    drain();
    check_val("b2b_count", 32'(win_cnt - base), 32'd8);
    check_val("b2b_nlast", 32'(last_idx.size()), 32'd2);
    if (last_idx.size() == 2) begin
      check_val("b2b_last_a", 32'(last_idx[0] - base), 32'd4);
      check_val("b2b_last_b", 32'(last_idx[1] - base), 32'd8);
    end

`ifdef FEEDER_FRAME_CNT_EN
    do_reset();
    check_val("fc_after_rst", 32'(frame_cnt), 32'd0);
    for (int f = 1; f <= 3; f++) begin
      send_frame(0);
      drain();
      check_val("fc_step", 32'(frame_cnt), 32'(f));
    end
    do_reset();
    check_val("fc_rst_again", 32'(frame_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Streaming 3x3 window generator that sits directly upstream of the neuron stage. It accepts a raster-order pixel stream one sample per handshake and buffers two image lines. It emits each fully populated 3x3 neighbourhood on nine 27-bit signed buses, matching the neuron's input ports, plus a 9-bit all-ones start vector. Windows use valid-only convolution: no padding, and only windows fully inside the image are emitted.

## Interface
- `IMG_W`, default 8: pixels per line; must be ≥ 3.
- `IMG_H`, default 8: lines per frame; must be ≥ 3.
- `DW`, default 27: pixel and window-tap width, signed.
- `clk`, input, 1: sole clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `pix_data`, input, DW: signed pixel, raster order, row-major from (0,0).
- `pix_valid`, input, 1: `pix_data` valid.
- `pix_ready`, output, 1: feeder accepts a pixel this cycle.
- `win_0` … `win_8`, output, DW each: window taps; `win_k` = pixel (r-2+k/3, c-2+k%3) for the centre-bottom-right pixel (r,c).
- `start_`, output, 9: `{9{win_valid}}`; drives the neuron `start_` directly.
- `win_valid`, output, 1: window taps valid.
- `win_ready`, input, 1: downstream consumes the window this cycle.
- `win_last`, output, 1: high with the final window of a frame, qualified by `win_valid`.
- `frame_cnt`, output, 16: present only with `FEEDER_FRAME_CNT_EN`.

## Operation
- Pixel accept: `acc = pix_valid & pix_ready`. `pix_ready = ~win_valid | win_ready` (single output register stage).
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on `acc`.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and the next pixel starts a new frame.
- Line buffers `lb0[IMG_W]` (row r-1) and `lb1[IMG_W]` (row r-2) are indexed by `col`. On `acc`:
  - New column = {`lb1[col]`, `lb0[col]`, `pix_data`}.
  - `lb1[col] <= lb0[col]`; `lb0[col] <= pix_data`.
- Window: 3 columns × 3 rows of registers. On `acc`, columns shift left (oldest column dropped) and the new column enters at the right.
- Taps `win_0..win_8` come straight from the window registers. `win_0` = top-left (oldest); `win_8` = the pixel just accepted.
- On `acc` with `row ≥ 2` and `col ≥ 2`, `win_valid <= 1` and `win_last <= (row==IMG_H-1 && col==IMG_W-1)`.
- Otherwise, on `win_valid & win_ready` with no qualifying accept, `win_valid <= 0` and `win_last <= 0`.
- Columns 0 and 1 of each row are shifted in but never emitted; stale columns from the previous row are flushed by the time `col = 2`.
- Backpressure: while `win_valid & ~win_ready`, `pix_ready = 0`. Taps, `win_valid` and `win_last` are held bit-stable and no pixel is lost.
- Arithmetic: none on data. Pixels are copied bit-exact, so sign is preserved. Counters use `$clog2` widths.

## Timing
- Reset values: `pix_ready` = 1 (because `win_valid` = 0); `win_valid`, `win_last`, `start_` = 0; all taps, line buffers and counters = 0; `frame_cnt` = 0.
- Latency: 1 cycle from accepting pixel (r,c≥2, r≥2) to `win_valid` high with its window.
- Throughput: 1 pixel/cycle when `win_ready` is held high.
- Simultaneous consume and new window in the same cycle: the new window replaces the old; `win_valid` stays 1.
- Reset mid-frame: the partial frame is discarded, `win_valid` drops the next cycle, and the next accepted pixel is (0,0).
- `pix_valid` gaps: no state change; the window holds.

## Configuration
- Macro: `FEEDER_FRAME_CNT_EN`.
- Defined: adds output `frame_cnt[15:0]`.
  - Increments by 1 in the cycle the last pixel of a frame is accepted, wrapping 16'hFFFF to 0.
  - Cleared by `rst`.
- Undefined: neither the port nor the counter exists; all other behaviour is identical.

## Test plan
- IMG_W=IMG_H=4, pixel(r,c)=10r+c, `win_ready`=1: exactly 4 windows.
  - First window: `win_0`=0, `win_4`=11, `win_8`=22.
  - Fourth window: `win_0`=11, `win_8`=33, with `win_last`=1.
  - `start_`=9'h1ff while valid.
- Same stream with `win_ready`=0 for 5 cycles on the first window: taps stay {0..22} and `pix_ready`=0 throughout. After release, the remaining 3 windows are correct and no pixel is dropped.
- All pixels = -1 (27'h7FFFFFF): every tap equals 27'h7FFFFFF and sign is preserved.
- `rst` pulsed after 6 pixels of a 4x4 frame: `win_valid`=0 next cycle. A full new frame then reproduces the first test exactly.
- Two 4x4 frames back-to-back with `pix_valid`=1 continuously: 8 windows, and `win_last` is high only on windows 4 and 8.
- `FEEDER_FRAME_CNT_EN` defined, three 4x4 frames: `frame_cnt` reads 0→1→2→3, and returns to 0 on `rst`.
